// File: rtl/tape_rx_pkg.sv
// Shared encodings for the tape frame receive controller.
// Symbol kinds, status bit positions and FSM state codes.
package tape_rx_pkg;

  localparam int LEN_W = 13;

  localparam logic [1:0] SYM_DATA    = 2'd0;
  localparam logic [1:0] SYM_BEGIN   = 2'd1;
  localparam logic [1:0] SYM_END     = 2'd2;
  localparam logic [1:0] SYM_INVALID = 2'd3;

  localparam int ERR_CSUM  = 0;
  localparam int ERR_OVF   = 1;
  localparam int ERR_PROTO = 2;
  localparam int ERR_TMO   = 3;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_SYNC    = 3'd1;
  localparam state_t S_HEADER  = 3'd2;
  localparam state_t S_PAYLOAD = 3'd3;
  localparam state_t S_CHECK   = 3'd4;
  localparam state_t S_TAIL    = 3'd5;
  localparam state_t S_DONE    = 3'd6;

endpackage

// File: rtl/rx_byte_fifo.sv
// Small synchronous byte FIFO with wrap-bit pointers.
// A pop frees the slot that a same-cycle push into a full FIFO uses.
module rx_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_pop, do_push;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tape_rx_ctrl.sv
// Frame receive controller: sync lock, length header, payload
// streaming through a FIFO, checksum and end-marker verification.
module tape_rx_ctrl
  import tape_rx_pkg::*;
#(
  parameter int SYNC_COUNT = 4,
  parameter int MAX_LEN    = 4096,
  parameter int TIMEOUT    = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             sym_valid,
  input  logic [1:0]       sym_kind,
  input  logic [3:0]       sym_data,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             lock,
  output logic             frame_start,
  output logic             frame_done,
  output logic [3:0]       frame_err,
  output logic [LEN_W-1:0] frame_len
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           st_q, st_d;
  logic [3:0]       sync_q, sync_d;
  logic [1:0]       nib_q, nib_d;
  logic [15:0]      hdr_q, hdr_d, hdr_new;
  logic [3:0]       hi_q, hi_d;
  logic             half_q, half_d;
  logic [7:0]       sum_q, sum_d, pbyte;
  logic [LEN_W-1:0] bcnt_q, bcnt_d, bcnt_inc;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       err_q, err_d;
  logic [TW-1:0]    idle_q, idle_d;
  logic             start_q, start_d;
  logic             push, is_data, locked;
  logic             f_full, f_empty;

  assign is_data  = sym_valid && (sym_kind == SYM_DATA);
  assign locked   = (st_q == S_HEADER) || (st_q == S_PAYLOAD) ||
                    (st_q == S_CHECK)  || (st_q == S_TAIL);
  assign hdr_new  = {hdr_q[11:0], sym_data};
  assign pbyte    = {hi_q, sym_data};
  assign bcnt_inc = bcnt_q + 1'b1;

  always_comb begin
    st_d    = st_q;
    sync_d  = sync_q;
    nib_d   = nib_q;
    hdr_d   = hdr_q;
    hi_d    = hi_q;
    half_d  = half_q;
    sum_d   = sum_q;
    bcnt_d  = bcnt_q;
    len_d   = len_q;
    err_d   = err_q;
    idle_d  = idle_q;
    start_d = 1'b0;
    push    = 1'b0;
    if (locked) idle_d = sym_valid ? '0 : idle_q + 1'b1;
    unique case (st_q)
      S_IDLE: begin
        if (sym_valid && sym_kind == SYM_BEGIN) begin
          sync_d = 4'd1;
          st_d   = S_SYNC;
        end
      end
      S_SYNC: begin
        if (sym_valid) begin
          if (sym_kind == SYM_BEGIN) begin
            sync_d = (sync_q == 4'd15) ? sync_q : sync_q + 1'b1;
          end else if (is_data && sync_q >= 4'(SYNC_COUNT)) begin
            st_d    = S_HEADER;
            start_d = 1'b1;
            hdr_d   = {12'd0, sym_data};
            nib_d   = 2'd1;
            err_d   = '0;
            idle_d  = '0;
            sync_d  = '0;
          end else begin
            st_d   = S_IDLE;
            sync_d = '0;
          end
        end
      end
      S_HEADER: begin
        if (is_data) begin
          hdr_d = hdr_new;
          nib_d = nib_q + 1'b1;
          if (nib_q == 2'd3) begin
            len_d  = hdr_new[LEN_W-1:0];
            half_d = 1'b0;
            sum_d  = '0;
            bcnt_d = '0;
            if (hdr_new == 16'd0 || hdr_new > 16'(MAX_LEN)) begin
              err_d[ERR_PROTO] = 1'b1;
              st_d = S_DONE;
            end else begin
              st_d = S_PAYLOAD;
            end
          end
        end else if (sym_valid) begin
          err_d[ERR_PROTO] = 1'b1;
          st_d = S_DONE;
        end
      end
      S_PAYLOAD: begin
        if (is_data) begin
          half_d = ~half_q;
          if (!half_q) begin
            hi_d = sym_data;
          end else begin
            push   = 1'b1;
            sum_d  = sum_q + pbyte;
            bcnt_d = bcnt_inc;
            // full with no pop this cycle: byte is lost but still counted
            if (f_full && !byte_ready) err_d[ERR_OVF] = 1'b1;
            if (bcnt_inc == len_q) st_d = S_CHECK;
          end
        end else if (sym_valid) begin
          err_d[ERR_PROTO] = 1'b1;
          st_d = S_DONE;
        end
      end
      S_CHECK: begin
        if (is_data) begin
          half_d = ~half_q;
          if (!half_q) begin
            hi_d = sym_data;
          end else begin
            if (pbyte != sum_q) err_d[ERR_CSUM] = 1'b1;
            st_d = S_TAIL;
          end
        end else if (sym_valid) begin
          err_d[ERR_PROTO] = 1'b1;
          st_d = S_DONE;
        end
      end
      S_TAIL: begin
        if (sym_valid) begin
          if (sym_kind != SYM_END) err_d[ERR_PROTO] = 1'b1;
          st_d = S_DONE;
        end
      end
      S_DONE: begin
        st_d   = S_IDLE;
        sync_d = '0;
      end
      default: st_d = S_IDLE;
    endcase
    if (locked && !sym_valid && idle_q == TW'(TIMEOUT - 1)) begin
      err_d[ERR_TMO] = 1'b1;
      st_d = S_DONE;
    end
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      sync_q  <= '0;
      nib_q   <= '0;
      hdr_q   <= '0;
      hi_q    <= '0;
      half_q  <= 1'b0;
      sum_q   <= '0;
      bcnt_q  <= '0;
      len_q   <= '0;
      err_q   <= '0;
      idle_q  <= '0;
      start_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      sync_q  <= sync_d;
      nib_q   <= nib_d;
      hdr_q   <= hdr_d;
      hi_q    <= hi_d;
      half_q  <= half_d;
      sum_q   <= sum_d;
      bcnt_q  <= bcnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
      start_q <= start_d;
    end
  end

  rx_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clkin),
    .rst_n (rst_n),
    .push  (push),
    .din   (pbyte),
    .full  (f_full),
    .pop   (byte_ready),
    .dout  (byte_data),
    .empty (f_empty)
  );

  assign byte_valid  = ~f_empty;
  assign lock        = locked;
  assign frame_start = start_q;
  assign frame_done  = (st_q == S_DONE);
  assign frame_err   = err_q;
  assign frame_len   = len_q;

endmodule

// File: tb/tb_tape_rx_ctrl.sv
// Directed bench for tape_rx_ctrl: a vector table for the good frame
// plus hand sequences for checksum, overflow, abort, timeout and reset.
module tb_tape_rx_ctrl;

  logic        clkin = 1'b0;
  logic        rst_n = 1'b0;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym_kind = 2'd0;
  logic [3:0]  sym_data = 4'd0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        lock;
  logic        frame_start;
  logic        frame_done;
  logic [3:0]  frame_err;
  logic [12:0] frame_len;

  int nchk = 0;
  int nfail = 0;
  int n_start = 0;
  int n_done = 0;
  logic [7:0] got[$];

  always #5 clkin = ~clkin;

  tape_rx_ctrl dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .sym_valid   (sym_valid),
    .sym_kind    (sym_kind),
    .sym_data    (sym_data),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .lock        (lock),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .frame_len   (frame_len)
  );

  always @(negedge clkin) begin
    if (rst_n) begin
      if (frame_start) n_start++;
      if (frame_done) n_done++;
      if (byte_valid && byte_ready) got.push_back(byte_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sym(input logic [1:0] k, input logic [3:0] d);
    sym_valid = 1'b1;
    sym_kind  = k;
    sym_data  = d;
    @(posedge clkin);
    @(negedge clkin);
    sym_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clkin);
  endtask

  task automatic send_byte(input logic [7:0] b);
    sym(2'd0, b[7:4]);
    sym(2'd0, b[3:0]);
  endtask

  task automatic send_hdr(input logic [15:0] h);
    sym(2'd0, h[15:12]);
    sym(2'd0, h[11:8]);
    sym(2'd0, h[7:4]);
    sym(2'd0, h[3:0]);
  endtask

  task automatic sync(input int n);
    for (int i = 0; i < n; i++) sym(2'd1, 4'd0);
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  k;
    logic [3:0]  d;
    logic        lk;
    logic        st;
    logic        dn;
    logic        bv;
    logic [7:0]  by;
    logic [12:0] ln;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int base, k0, k, s0, d0;
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 8'h00, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 8'h00, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 8'h00, 0};
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 0, 8'h00, 0};
    tbl[4]  = '{1, 0, 0, 1, 1, 0, 0, 8'h00, 0};
    tbl[5]  = '{1, 0, 0, 1, 0, 0, 0, 8'h00, 0};
    tbl[6]  = '{1, 0, 0, 1, 0, 0, 0, 8'h00, 0};
    tbl[7]  = '{1, 0, 3, 1, 0, 0, 0, 8'h00, 3};
    tbl[8]  = '{1, 0, 1, 1, 0, 0, 0, 8'h00, 3};
    tbl[9]  = '{1, 0, 2, 1, 0, 0, 1, 8'h12, 3};
    tbl[10] = '{1, 0, 3, 1, 0, 0, 0, 8'h00, 3};
    tbl[11] = '{1, 0, 4, 1, 0, 0, 1, 8'h34, 3};
    tbl[12] = '{1, 0, 10, 1, 0, 0, 0, 8'h00, 3};
    tbl[13] = '{1, 0, 11, 1, 0, 0, 1, 8'hAB, 3};
    tbl[14] = '{1, 0, 15, 1, 0, 0, 0, 8'h00, 3};
    tbl[15] = '{1, 0, 1, 1, 0, 0, 0, 8'h00, 3};
    tbl[16] = '{1, 2, 0, 0, 0, 1, 0, 8'h00, 3};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 3};

    // reset state
    repeat (3) @(posedge clkin);
    @(negedge clkin);
    chk("rst_lock", lock, 0);
    chk("rst_bvalid", byte_valid, 0);
    chk("rst_bdata", byte_data, 0);
    chk("rst_start", frame_start, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_len", frame_len, 0);
    rst_n = 1'b1;
    idle(2);

    // good frame, one symbol per cycle
    byte_ready = 1'b1;
    s0 = n_start;
    for (int i = 0; i < 18; i++) begin
      sym_valid = tbl[i].v;
      sym_kind  = tbl[i].k;
      sym_data  = tbl[i].d;
      @(posedge clkin);
      @(negedge clkin);
      chk($sformatf("good%0d_lock", i), lock, tbl[i].lk);
      chk($sformatf("good%0d_start", i), frame_start, tbl[i].st);
      chk($sformatf("good%0d_done", i), frame_done, tbl[i].dn);
      chk($sformatf("good%0d_bvalid", i), byte_valid, tbl[i].bv);
      if (tbl[i].bv)
        chk($sformatf("good%0d_byte", i), byte_data, tbl[i].by);
      chk($sformatf("good%0d_len", i), frame_len, tbl[i].ln);
      if (tbl[i].dn) chk("good_err", frame_err, 4'b0000);
    end
    sym_valid = 1'b0;
    chk("good_nstart", n_start - s0, 1);
    idle(2);

    // short sync
    s0 = n_start;
    sync(3);
    sym(2'd0, 4'd0);
    chk("short_lock", lock, 0);
    idle(3);
    chk("short_lock2", lock, 0);
    chk("short_nstart", n_start - s0, 0);

    // bad checksum
    base = got.size();
    sync(4);
    send_hdr(16'd3);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    send_byte(8'hF0);
    sym(2'd2, 4'd0);
    chk("csum_done", frame_done, 1);
    chk("csum_err", frame_err, 4'b0001);
    chk("csum_nbytes", got.size() - base, 3);
    if (got.size() - base >= 3) begin
      chk("csum_b0", got[base], 8'h12);
      chk("csum_b1", got[base+1], 8'h34);
      chk("csum_b2", got[base+2], 8'hAB);
    end
    idle(2);

    // overflow: 10 bytes into an 8-deep FIFO with consumer stalled
    byte_ready = 1'b0;
    sync(4);
    send_hdr(16'd10);
    for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i));
    send_byte(8'hCD);
    sym(2'd2, 4'd0);
    chk("ovf_done", frame_done, 1);
    chk("ovf_err", frame_err, 4'b0010);
    chk("ovf_bvalid", byte_valid, 1);
    base = got.size();
    byte_ready = 1'b1;
    idle(12);
    chk("ovf_nbytes", got.size() - base, 8);
    if (got.size() - base >= 8)
      for (int i = 0; i < 8; i++)
        chk($sformatf("ovf_b%0d", i), got[base+i], 8'h10 + 8'(i));
    chk("ovf_drained", byte_valid, 0);

    // abort with end marker mid-payload
    sync(4);
    send_hdr(16'd5);
    send_byte(8'h55);
    sym(2'd2, 4'd0);
    chk("abort_done", frame_done, 1);
    chk("abort_err", frame_err, 4'b0100);
    idle(2);
    chk("abort_lock", lock, 0);

    // timeout in payload
    d0 = n_done;
    sync(4);
    send_hdr(16'd5);
    send_byte(8'h01);
    k = 0;
    while (!frame_done && k < 1100) begin
      @(negedge clkin);
      k++;
    end
    chk("tmo_seen", frame_done, 1);
    chk("tmo_cycles", k, 1024);
    chk("tmo_err", frame_err, 4'b1000);
    idle(2);
    chk("tmo_ndone", n_done - d0, 1);

    // illegal lengths
    sync(4);
    send_hdr(16'h0000);
    chk("len0_done", frame_done, 1);
    chk("len0_err", frame_err, 4'b0100);
    idle(2);
    sync(4);
    send_hdr(16'd4097);
    chk("len4097_done", frame_done, 1);
    chk("len4097_err", frame_err, 4'b0100);
    idle(2);
    sync(4);
    send_hdr(16'h2001);
    chk("lenhi_done", frame_done, 1);
    chk("lenhi_err", frame_err, 4'b0100);
    idle(2);

    // saturated sync count, then a 1-byte frame at MAX_LEN-free path
    sync(20);
    send_hdr(16'd1);
    chk("sat_lock", lock, 1);
    send_byte(8'h7E);
    send_byte(8'h7E);
    sym(2'd2, 4'd0);
    chk("sat_done", frame_done, 1);
    chk("sat_err", frame_err, 4'b0000);
    chk("sat_len", frame_len, 1);
    idle(2);

    // reset mid-payload
    byte_ready = 1'b0;
    d0 = n_done;
    sync(4);
    send_hdr(16'd5);
    send_byte(8'h9C);
    sym(2'd0, 4'd3);
    chk("mid_bvalid_pre", byte_valid, 1);
    rst_n = 1'b0;
    @(posedge clkin);
    @(negedge clkin);
    chk("mid_lock", lock, 0);
    chk("mid_bvalid", byte_valid, 0);
    chk("mid_done", frame_done, 0);
    rst_n = 1'b1;
    idle(5);
    chk("mid_ndone", n_done - d0, 0);
    chk("mid_lock2", lock, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/tape_rx_ctrl.md
Name: tape_rx_ctrl

Overview:
- Frame-level receive controller downstream of the luma symbol demodulator.
- Consumes classified 4-bit symbols (data / begin marker / end marker / invalid) and acquires lock on a run of begin markers.
- Assembles nibbles into bytes, parses the length header and streams payload bytes through an internal FIFO on a valid/ready interface.
- Verifies the trailing checksum and end marker, and reports per-frame status to the tape capture logic.

Parameters:
SYNC_COUNT, 4, consecutive begin-marker symbols required to enter lock (range 1..15)
MAX_LEN, 4096, largest legal payload length in bytes
TIMEOUT, 1024, clkin cycles allowed between sym_valid strobes once locked
FIFO_DEPTH, 8, output FIFO entries (power of two)

Ports:
clkin  in  1  system clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
sym_valid  in  1  single-cycle symbol strobe
sym_kind  in  2  0=data, 1=begin marker, 2=end marker, 3=invalid
sym_data  in  4  nibble; meaningful only when sym_kind=0
byte_data  out  8  payload byte at FIFO head
byte_valid  out  1  FIFO non-empty
byte_ready  in  1  consumer accepts byte_data when byte_valid & byte_ready
lock  out  1  high from HEADER entry until frame end or abort
frame_start  out  1  one-cycle pulse on HEADER entry
frame_done  out  1  one-cycle pulse at frame end, good or bad
frame_err  out  4  status valid with frame_done: [0] checksum, [1] overflow, [2] protocol, [3] timeout
frame_len  out  13  decoded length; held until next HEADER entry

Behaviour:
- Clock and reset: one clock, clkin. Reset is synchronous, active-low (rst_n). In reset, all outputs are 0, FIFO is empty, state is IDLE and all counters are 0.
- States:
  - IDLE: a begin marker sets sync_cnt=1 and moves to SYNC.
  - SYNC: each begin marker increments sync_cnt. Any other symbol returns to IDLE with sync_cnt=0 (no frame_done). A data symbol arriving when sync_cnt>=SYNC_COUNT is instead taken as header nibble 0; enter HEADER, pulse frame_start, assert lock.
  - HEADER: collect 4 nibbles, MSB first, into a 16-bit length. Upper 3 bits must be 0, and length must be in 1..MAX_LEN; otherwise protocol error. frame_len updates on the 4th nibble.
  - PAYLOAD: nibble pairs form bytes (first nibble = bits[7:4]). Each byte is pushed to the FIFO and added to an 8-bit running sum (mod 256). A byte counter reaching frame_len moves to CHECK.
  - CHECK: 2 nibbles form a byte compared with the sum; a mismatch sets err[0]. Then go to TAIL.
  - TAIL: the next symbol must be an end marker; otherwise err[2]. Then go to DONE.
  - DONE: for one cycle, pulse frame_done with the accumulated frame_err, drop lock, return to IDLE.
- Extra begin markers in SYNC saturate sync_cnt at 15.
- Abort: in HEADER/PAYLOAD/CHECK, any non-data symbol sets err[2] and goes to DONE immediately; the partial byte is discarded.
- Timeout: an idle counter runs in HEADER through TAIL and clears on each sym_valid. Reaching TIMEOUT sets err[3] and goes to DONE.
- Overflow: a byte push while the FIFO is full drops the byte and sets err[1]. The frame continues, and the byte still counts toward the sum and length.
- FIFO: push and pop in the same cycle while full is allowed (the pop frees the slot; no overflow). byte_data/byte_valid come from registered FIFO state. Latency is one cycle from the 2nd nibble strobe to byte_valid.
- The FIFO is not flushed on DONE; already-delivered bytes remain. The consumer uses frame_done/frame_err to discard the frame.
- Reset mid-frame: next clkin edge with rst_n=0 empties the FIFO, returns to IDLE and emits no frame_done.
- Symbols with sym_valid=0 are ignored. No back-pressure is applied to the demodulator.

Decomposition:
- Package tape_rx_pkg:
  - sym_kind encodings (SYM_DATA, SYM_BEGIN, SYM_END, SYM_INVALID)
  - frame_err bit indices
  - state enum (IDLE, SYNC, HEADER, PAYLOAD, CHECK, TAIL, DONE)
  - LEN_W=13
- Sub-module rx_byte_fifo: synchronous FIFO parameterised by depth. Ports: push, din, full, pop, dout, empty.

Test Plan:
- Good frame: 4 begin markers, then nibbles 0,0,0,3, payload 1,2,3,4,A,B, checksum F,1, then end marker, byte_ready=1.
  - Required: frame_start once; bytes 0x12,0x34,0xAB in order; frame_len=3; frame_done with frame_err=0.
- Short sync: 3 begin markers, then data 0 → stays IDLE, no frame_start, no lock.
- Bad checksum: same as good frame but checksum 0xF0 → all 3 bytes delivered; frame_err=4'b0001.
- Overflow: FIFO_DEPTH=8, length 10, byte_ready=0 → 8 bytes held, 2 dropped. frame_err[1]=1 at frame_done; releasing byte_ready then yields the first 8 bytes in order.
- Abort and timeout:
  - End marker after 1 payload byte of a length-5 frame → frame_done with frame_err=4'b0100.
  - Separately, stop symbols in PAYLOAD for TIMEOUT cycles → frame_err=4'b1000.
- Bad length and reset:
  - Header 0x0000 → frame_err[2] at frame_done.
  - rst_n=0 for one cycle mid-PAYLOAD → next cycle lock=0, byte_valid=0, no frame_done.
